// File: rtl/symbol_tx_pkg.sv
// Shared types and constants for the symbol pattern transmitter.
package symbol_tx_pkg;

  localparam int unsigned SYM_W = 2;
  localparam logic [SYM_W-1:0] IDLE_SYM = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/symbol_pattern_ram.sv
// DEPTH x SYM_W pattern register file: one synchronous write port, one asynchronous read port.
module symbol_pattern_ram
  import symbol_tx_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [SYM_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [SYM_W-1:0]  o_rdata
);

  logic [SYM_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/symbol_pattern_tx.sv
// Plays a stored 2-bit symbol pattern out over a valid/ready handshake and pulses done at the end.
// Optional feature: define PATTERN_TX_LOOP_EN to add the loop input for continuous repeated playback.
module symbol_pattern_tx
  import symbol_tx_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  input  logic              sym_ready,
`ifdef PATTERN_TX_LOOP_EN
  input  logic              loop,
`endif
  output logic [SYM_W-1:0]  sym,
  output logic              sym_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_t            r_state, w_state_n;
  logic [ADDR_W:0]   r_idx, w_idx_n;
  logic [ADDR_W:0]   r_len_q, w_len_n;
  logic [ADDR_W:0]   w_len_sat;
  logic              w_at_last;
  logic              w_wrap;
  logic              w_we;
  logic [SYM_W-1:0]  w_rdata;

  // idx and len_q carry one extra bit so len==DEPTH compares without aliasing to 0.
  assign w_len_sat = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_at_last = (r_idx == (r_len_q - IDX_ONE));
  assign w_we      = wr_en && (r_state == ST_IDLE);

`ifdef PATTERN_TX_LOOP_EN
  assign w_wrap = loop;
`else
  assign w_wrap = 1'b0;
`endif

  symbol_pattern_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(wr_addr),
    .i_wdata(wr_data),
    .i_raddr(r_idx[ADDR_W-1:0]),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len_q <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_len_q <= w_len_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_len_n   = r_len_q;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_len_n   = w_len_sat;
          w_idx_n   = '0;
          w_state_n = (w_len_sat == '0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (sym_ready) begin
          if (!w_at_last) begin
            w_idx_n = r_idx + IDX_ONE;
          end else if (w_wrap) begin
            w_idx_n = '0;
          end else begin
            w_state_n = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign sym_valid = (r_state == ST_SEND);
  assign sym       = sym_valid ? w_rdata : IDLE_SYM;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_symbol_pattern_tx.sv
// Self-checking bench for symbol_pattern_tx: directed cases plus randomized patterns/lengths/backpressure.
module tb_symbol_pattern_tx;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;
`ifdef PATTERN_TX_LOOP_EN
  localparam bit HAS_LOOP = 1'b1;
`else
  localparam bit HAS_LOOP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [1:0]        wr_data = '0;
  logic [ADDR_W:0]   len = '0;
  logic              start = 1'b0;
  logic              sym_ready = 1'b0;
  logic              loop = 1'b0;
  logic [1:0]        sym;
  logic              sym_valid;
  logic              busy;
  logic              done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  model_mem [DEPTH];

  symbol_pattern_tx #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .len      (len),
    .start    (start),
    .sym_ready(sym_ready),
`ifdef PATTERN_TX_LOOP_EN
    .loop     (loop),
`endif
    .sym      (sym),
    .sym_valid(sym_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(sym_valid), 0);
    chk({tag, "_sym"}, 32'(sym), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic write_mem(input int unsigned a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Expected stream: symbol k of the playback is pattern[k mod L]; total L*passes symbols, then one done cycle.
  task automatic play(input int unsigned len_in, input int unsigned ready_pct, input int unsigned passes,
                      input bit disturb, input int stall_at, input int abort_at);
    int unsigned L, T, k, stalls;
    bit          rdy, finished;
    L = (len_in > DEPTH) ? DEPTH : len_in;
    T = L * passes;
    k = 0; stalls = 0; finished = 1'b0;
    start = 1'b1; len = (ADDR_W + 1)'(len_in);
    loop = HAS_LOOP && (passes > 1);
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (abort_at >= 0 && k == int'(abort_at)) begin
        rst = 1'b1; sym_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort_hold");
        finished = 1'b1;
        break;
      end
      if (k < T) begin
        chk("valid", 32'(sym_valid), 1);
        chk("sym", 32'(sym), 32'(model_mem[k % L]));
        chk("busy", 32'(busy), 1);
        chk("done_early", 32'(done), 0);
        rdy = ($urandom_range(99) < ready_pct);
        if (stall_at >= 0 && k == int'(stall_at) && stalls < 3) begin
          rdy = 1'b0; stalls++;
        end
        sym_ready = rdy;
        loop = HAS_LOOP && ((k / L) + 1 < passes);
        if (disturb) begin
          wr_en = $urandom_range(1) == 1; wr_addr = ADDR_W'($urandom_range(DEPTH - 1));
          wr_data = 2'($urandom_range(3)); start = $urandom_range(1) == 1;
          len = (ADDR_W + 1)'($urandom_range(15));
        end
        tick();
        if (rdy) k++;
      end else begin
        sym_ready = 1'b0; wr_en = 1'b0; start = 1'b0; loop = 1'b0;
        chk("done", 32'(done), 1);
        chk("done_valid", 32'(sym_valid), 0);
        chk("done_sym", 32'(sym), 0);
        chk("done_busy", 32'(busy), 1);
        tick();
        chk_idle("after_done");
        finished = 1'b1;
        break;
      end
    end
    if (!finished) chk("timeout", 0, 1);
  endtask

  initial begin
    int unsigned n_rand;
    tick(); tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Case 1: four-symbol pattern, ready always high.
    write_mem(0, 2'b01); write_mem(1, 2'b10); write_mem(2, 2'b11); write_mem(3, 2'b00);
    play(4, 100, 1, 1'b0, -1, -1);

    // Case 2: three-cycle stall on beat 1.
    play(4, 100, 1, 1'b0, 1, -1);

    // Case 3: zero length goes straight to done.
    play(0, 100, 1, 1'b0, -1, -1);

    // Case 4: full depth with writes/starts attempted mid-playback.
    for (int unsigned a = 0; a < DEPTH; a++) write_mem(a, 2'($urandom_range(3)));
    play(8, 100, 1, 1'b1, -1, -1);
    play(13, 70, 1, 1'b0, -1, -1);

    // Case 5: reset at beat 2, then replay from the intact RAM.
    play(4, 100, 1, 1'b0, -1, 2);
    play(4, 100, 1, 1'b0, -1, -1);

    // Write and start in the same cycle: playback sees the new value.
    wr_en = 1'b1; wr_addr = '0; wr_data = ~model_mem[0];
    model_mem[0] = ~model_mem[0];
    play(3, 100, 1, 1'b0, -1, -1);

    // Case 6: three passes of a three-symbol loop.
    if (HAS_LOOP) play(3, 100, 3, 1'b0, -1, -1);

    // Randomized patterns, lengths, backpressure and disturbances.
    n_rand = 25;
    for (int unsigned it = 0; it < n_rand; it++) begin
      for (int unsigned a = 0; a < DEPTH; a++) write_mem(a, 2'($urandom_range(3)));
      play($urandom_range(15), 30 + $urandom_range(70), HAS_LOOP ? 1 + $urandom_range(2) : 1,
           $urandom_range(1) == 1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
